// File: rtl/otter_io_pkg.sv
// Shared constants for the OTTER I/O controller: register map, bit positions
// inside TCTL/ISTAT, and the button debounce state encoding.
package otter_io_pkg;

  localparam logic [31:0] ADDR_SW    = 32'h1100_0000;
  localparam logic [31:0] ADDR_LED   = 32'h1100_0020;
  localparam logic [31:0] ADDR_TCMP  = 32'h1100_0040;
  localparam logic [31:0] ADDR_TCTL  = 32'h1100_0044;
  localparam logic [31:0] ADDR_TCNT  = 32'h1100_0048;
  localparam logic [31:0] ADDR_ISTAT = 32'h1100_004C;
  localparam logic [31:0] ADDR_IMASK = 32'h1100_0050;

  localparam int TCTL_EN   = 0;
  localparam int TCTL_AUTO = 1;
  localparam int ISTAT_TMR = 0;
  localparam int ISTAT_BTN = 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM for the interrupt button; emits a
// single-cycle pulse on the clock edge where a press is accepted.
import otter_io_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q;

  assign btn_s = sync_q[1];

  // Combinational from flops so the status bit sets on the same edge the FSM enters HELD.
  assign press_o = (state_q == DB_PRESS) && btn_s && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= DB_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= DB_RELEASE;
            cnt_q   <= '0;
          end
        end
        DB_RELEASE: begin
          if (btn_s) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/otter_io_ctrl.sv
// Memory-mapped I/O block for the OTTER MCU: switches, LEDs, a compare timer
// and a debounced button, with a masked, sticky interrupt status register.
import otter_io_pkg::*;

module otter_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR,
  input  logic [15:0] SWITCHES,
  input  logic        BTN_INT,
  output logic [15:0] LEDS
);

  logic [15:0] sw_meta_q, sw_sync_q;
  logic [15:0] led_q, led_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [1:0]  tctl_q, tctl_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [1:0]  istat_q, istat_d;
  logic [1:0]  imask_q, imask_d;
  logic [1:0]  istat_set, istat_clr;
  logic        wr_led, wr_tcmp, wr_tctl, wr_istat, wr_imask;
  logic        tmr_run, tmr_hit, btn_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .btn_i  (BTN_INT),
    .press_o(btn_press)
  );

  assign wr_led   = IOBUS_WR && (IOBUS_ADDR == ADDR_LED);
  assign wr_tcmp  = IOBUS_WR && (IOBUS_ADDR == ADDR_TCMP);
  assign wr_tctl  = IOBUS_WR && (IOBUS_ADDR == ADDR_TCTL);
  assign wr_istat = IOBUS_WR && (IOBUS_ADDR == ADDR_ISTAT);
  assign wr_imask = IOBUS_WR && (IOBUS_ADDR == ADDR_IMASK);

  assign tmr_run = tctl_q[TCTL_EN] && (tcmp_q != 32'd0);
  assign tmr_hit = tmr_run && (tcnt_q == tcmp_q - 32'd1);

  always_comb begin
    led_d     = led_q;
    tcmp_d    = tcmp_q;
    tctl_d    = tctl_q;
    tcnt_d    = tcnt_q;
    imask_d   = imask_q;
    istat_set = '0;
    istat_clr = '0;

    if (wr_led)   led_d   = IOBUS_OUT[15:0];
    if (wr_tcmp)  tcmp_d  = IOBUS_OUT;
    if (wr_imask) imask_d = IOBUS_OUT[1:0];

    // One-shot mode drops EN on the match edge; a software TCTL write still wins.
    if (tmr_hit && !tctl_q[TCTL_AUTO]) tctl_d[TCTL_EN] = 1'b0;
    if (wr_tctl) tctl_d = IOBUS_OUT[1:0];

    if (wr_tctl || wr_tcmp) tcnt_d = '0;
    else if (tmr_hit)       tcnt_d = '0;
    else if (tmr_run)       tcnt_d = tcnt_q + 32'd1;

    istat_set[ISTAT_TMR] = tmr_hit;
    istat_set[ISTAT_BTN] = btn_press;
    if (wr_istat) istat_clr = IOBUS_OUT[1:0];
    istat_d = (istat_q & ~istat_clr) | istat_set;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      tcmp_q    <= '0;
      tctl_q    <= '0;
      tcnt_q    <= '0;
      istat_q   <= '0;
      imask_q   <= '0;
    end else begin
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      tcmp_q    <= tcmp_d;
      tctl_q    <= tctl_d;
      tcnt_q    <= tcnt_d;
      istat_q   <= istat_d;
      imask_q   <= imask_d;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    case (IOBUS_ADDR)
      ADDR_SW:    IOBUS_IN = {16'h0, sw_sync_q};
      ADDR_LED:   IOBUS_IN = {16'h0, led_q};
      ADDR_TCMP:  IOBUS_IN = tcmp_q;
      ADDR_TCTL:  IOBUS_IN = {30'h0, tctl_q};
      ADDR_TCNT:  IOBUS_IN = tcnt_q;
      ADDR_ISTAT: IOBUS_IN = {30'h0, istat_q};
      ADDR_IMASK: IOBUS_IN = {30'h0, imask_q};
      default:    IOBUS_IN = '0;
    endcase
  end

  assign INTR = |(istat_q & imask_q);
  assign LEDS = led_q;

endmodule

// File: tb/tb_otter_io_ctrl.sv
// Directed bench for otter_io_ctrl: register map, switch sync latency, timer
// periodic/one-shot/disable behaviour, button debounce, and async reset.
import otter_io_pkg::*;

module tb_otter_io_ctrl;

  localparam int DB = 8;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iobus_addr = '0;
  logic [31:0] iobus_out = '0;
  logic        iobus_wr = 1'b0;
  logic [31:0] iobus_in;
  logic        intr;
  logic [15:0] switches = '0;
  logic        btn_int = 1'b0;
  logic [15:0] leds;

  always #5 clk = ~clk;

  otter_io_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IOBUS_ADDR(iobus_addr),
    .IOBUS_OUT (iobus_out),
    .IOBUS_WR  (iobus_wr),
    .IOBUS_IN  (iobus_in),
    .INTR      (intr),
    .SWITCHES  (switches),
    .BTN_INT   (btn_int),
    .LEDS      (leds)
  );

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    @(negedge clk);
    iobus_wr   = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    expect_val(exp);
    iobus_addr = addr;
    #1;
    check(tag, iobus_in);
  endtask

  task automatic pin_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(exp);
    check(tag, obs);
  endtask

  initial begin
    // reset state
    switches = 16'h1234;
    #2;
    pin_chk("rst_leds", {16'h0, leds}, 32'h0);
    pin_chk("rst_intr", {31'h0, intr}, 32'h0);
    rd_chk(ADDR_SW,  32'h0, "rst_sw");
    rd_chk(ADDR_LED, 32'h0, "rst_led");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // switch synchronizer latency
    cyc(3);
    rd_chk(ADDR_SW, 32'h0000_1234, "sw_sync");
    switches = 16'hBEEF;
    cyc(1);
    rd_chk(ADDR_SW, 32'h0000_1234, "sw_lat1");
    cyc(1);
    rd_chk(ADDR_SW, 32'h0000_BEEF, "sw_lat2");

    // LED register, read-only and unmapped writes
    bus_wr(ADDR_LED, 32'h0000_A5A5);
    pin_chk("leds_a5a5", {16'h0, leds}, 32'h0000_A5A5);
    rd_chk(ADDR_LED, 32'h0000_A5A5, "led_rd");
    bus_wr(ADDR_LED, 32'hFFFF_1234);
    rd_chk(ADDR_LED, 32'h0000_1234, "led_upper0");
    bus_wr(ADDR_SW, 32'h0000_0000);
    rd_chk(ADDR_SW, 32'h0000_BEEF, "sw_ro");
    bus_wr(32'h1100_0024, 32'hDEAD_BEEF);
    rd_chk(32'h1100_0024, 32'h0, "unmapped_rd");
    rd_chk(ADDR_LED, 32'h0000_1234, "led_after_unmapped");
    bus_wr(ADDR_IMASK, 32'hFFFF_FFFF);
    rd_chk(ADDR_IMASK, 32'h3, "imask_bits");
    bus_wr(ADDR_IMASK, 32'h1);

    // periodic timer, period 5
    bus_wr(ADDR_TCMP, 32'd5);
    bus_wr(ADDR_TCTL, 32'h3);
    rd_chk(ADDR_TCTL, 32'h3, "tctl_rd");
    rd_chk(ADDR_TCNT, 32'h0, "tcnt_start");
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      rd_chk(ADDR_TCNT, k, "tcnt_inc");
      rd_chk(ADDR_ISTAT, 32'h0, "istat_pre");
    end
    cyc(1);
    rd_chk(ADDR_ISTAT, 32'h1, "tmr_set1");
    rd_chk(ADDR_TCNT, 32'h0, "tcnt_wrap");
    pin_chk("intr_tmr1", {31'h0, intr}, 32'h1);
    bus_wr(ADDR_ISTAT, 32'h1);
    rd_chk(ADDR_ISTAT, 32'h0, "w1c_clear");
    pin_chk("intr_clear", {31'h0, intr}, 32'h0);
    rd_chk(ADDR_TCNT, 32'h1, "tcnt_after_clr");
    cyc(3);
    rd_chk(ADDR_ISTAT, 32'h0, "tmr_not_yet");
    cyc(1);
    rd_chk(ADDR_ISTAT, 32'h1, "tmr_set2");
    rd_chk(ADDR_TCNT, 32'h0, "tcnt_wrap2");

    // clear on the same edge as a new match: set wins
    cyc(4);
    rd_chk(ADDR_TCNT, 32'h4, "tcnt_before_race");
    bus_wr(ADDR_ISTAT, 32'h1);
    rd_chk(ADDR_ISTAT, 32'h1, "race_set_wins");
    pin_chk("race_intr", {31'h0, intr}, 32'h1);
    rd_chk(ADDR_TCNT, 32'h0, "race_tcnt");

    // stop the timer
    bus_wr(ADDR_TCTL, 32'h0);
    rd_chk(ADDR_TCNT, 32'h0, "tctl_wr_rst_cnt");
    bus_wr(ADDR_ISTAT, 32'h3);
    cyc(6);
    rd_chk(ADDR_TCNT, 32'h0, "en0_hold");
    rd_chk(ADDR_ISTAT, 32'h0, "en0_no_irq");

    // TCMP = 0 disables counting
    bus_wr(ADDR_TCMP, 32'd0);
    bus_wr(ADDR_TCTL, 32'h1);
    cyc(10);
    rd_chk(ADDR_TCNT, 32'h0, "tcmp0_hold");
    rd_chk(ADDR_ISTAT, 32'h0, "tcmp0_no_irq");
    rd_chk(ADDR_TCTL, 32'h1, "tcmp0_tctl");

    // one-shot
    bus_wr(ADDR_TCMP, 32'd5);
    bus_wr(ADDR_TCTL, 32'h1);
    cyc(4);
    rd_chk(ADDR_TCNT, 32'h4, "os_tcnt4");
    rd_chk(ADDR_ISTAT, 32'h0, "os_pre");
    cyc(1);
    rd_chk(ADDR_ISTAT, 32'h1, "os_set");
    rd_chk(ADDR_TCTL, 32'h0, "os_en_clr");
    pin_chk("os_intr", {31'h0, intr}, 32'h1);
    cyc(10);
    rd_chk(ADDR_TCNT, 32'h0, "os_tcnt_stay");
    rd_chk(ADDR_TCTL, 32'h0, "os_tctl_stay");
    bus_wr(ADDR_ISTAT, 32'h1);
    cyc(10);
    rd_chk(ADDR_ISTAT, 32'h0, "os_single");

    // button: 3 bounce cycles then a 20-cycle hold
    bus_wr(ADDR_IMASK, 32'h2);
    btn_int = 1'b1; cyc(1);
    btn_int = 1'b0; cyc(1);
    btn_int = 1'b1; cyc(1);
    cyc(4);
    rd_chk(ADDR_ISTAT, 32'h0, "btn_early");
    cyc(11);
    rd_chk(ADDR_ISTAT, 32'h2, "btn_set");
    pin_chk("btn_intr", {31'h0, intr}, 32'h1);
    bus_wr(ADDR_ISTAT, 32'h2);
    cyc(4);
    rd_chk(ADDR_ISTAT, 32'h0, "btn_once_held");
    btn_int = 1'b0;
    cyc(20);
    rd_chk(ADDR_ISTAT, 32'h0, "btn_once_rel");
    pin_chk("btn_intr_off", {31'h0, intr}, 32'h0);

    // 5-cycle pulse is rejected
    btn_int = 1'b1; cyc(5);
    btn_int = 1'b0; cyc(20);
    rd_chk(ADDR_ISTAT, 32'h0, "btn_short");

    // a second long press is accepted again
    btn_int = 1'b1; cyc(20);
    rd_chk(ADDR_ISTAT, 32'h2, "btn_second");
    btn_int = 1'b0; cyc(20);
    bus_wr(ADDR_ISTAT, 32'h3);
    rd_chk(ADDR_ISTAT, 32'h0, "btn_second_clr");

    // async reset mid-count with both status bits pending
    bus_wr(ADDR_IMASK, 32'h3);
    bus_wr(ADDR_TCMP, 32'd5);
    bus_wr(ADDR_TCTL, 32'h3);
    btn_int = 1'b1;
    cyc(15);
    rd_chk(ADDR_ISTAT, 32'h3, "pre_rst_istat");
    pin_chk("pre_rst_intr", {31'h0, intr}, 32'h1);
    #1;
    rst_n   = 1'b0;
    btn_int = 1'b0;
    #1;
    pin_chk("arst_leds", {16'h0, leds}, 32'h0);
    pin_chk("arst_intr", {31'h0, intr}, 32'h0);
    rd_chk(ADDR_ISTAT, 32'h0, "arst_istat");
    rd_chk(ADDR_TCTL, 32'h0, "arst_tctl");
    rd_chk(ADDR_TCMP, 32'h0, "arst_tcmp");
    rd_chk(ADDR_SW, 32'h0, "arst_sw");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);
    rd_chk(ADDR_ISTAT, 32'h0, "post_rst_istat");
    pin_chk("post_rst_intr", {31'h0, intr}, 32'h0);
    rd_chk(ADDR_TCNT, 32'h0, "post_rst_tcnt");
    rd_chk(ADDR_TCTL, 32'h0, "post_rst_tctl");
    rd_chk(ADDR_LED, 32'h0, "post_rst_led");
    rd_chk(ADDR_SW, 32'h0000_BEEF, "post_rst_sw");

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_io_ctrl.md
OTTER_IO_CTRL -- requirements
Module: otter_io_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles required before a button level change is accepted.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 IOBUS_ADDR  input  32  MCU bus address, ALU result.
REQ-005 IOBUS_OUT  input  32  MCU write data, rs2.
REQ-006 IOBUS_WR  input  1  MCU write strobe, one cycle per store.
REQ-007 IOBUS_IN  output  32  read data returned to MCU.
REQ-008 INTR  output  1  level interrupt request to MCU.
REQ-009 SWITCHES  input  16  board switches, asynchronous.
REQ-010 BTN_INT  input  1  interrupt button, asynchronous, bouncy.
REQ-011 LEDS  output  16  board LEDs.

Function
REQ-012 Register map SHALL be: 0x11000000 SW (R), 0x11000020 LED (RW, bits[15:0]), 0x11000040 TCMP (RW, 32b), 0x11000044 TCTL (RW: bit0 EN, bit1 AUTO), 0x11000048 TCNT (R), 0x1100004C ISTAT (R, W1C: bit0 TMR, bit1 BTN), 0x11000050 IMASK (RW, bits[1:0]).
REQ-013 IOBUS_IN SHALL be combinational from IOBUS_ADDR; unmapped addresses and unused bits read 0.
REQ-014 A write SHALL take effect on the CLK edge where IOBUS_WR=1; writes to read-only or unmapped addresses are ignored.
REQ-015 SWITCHES and BTN_INT SHALL each pass a 2-flop synchronizer; SW reads return the synchronized value (2-cycle latency).
REQ-016 Debounce FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE.
REQ-017 IDLE->DB_PRESS when sync button=1; counter cleared.
REQ-018 DB_PRESS: counter increments while button=1; returns to IDLE if button=0; ->HELD when counter reaches DEBOUNCE_CYCLES-1, setting ISTAT.BTN that edge.
REQ-019 HELD->DB_RELEASE when button=0; DB_RELEASE->IDLE after DEBOUNCE_CYCLES consecutive 0 cycles, back to HELD on any 1.
REQ-020 One accepted press SHALL set ISTAT.BTN exactly once.
REQ-021 Timer: while TCTL.EN=1 and TCMP!=0, TCNT increments by 1 per cycle.
REQ-022 When TCNT==TCMP-1 on an increment cycle, next edge SHALL set ISTAT.TMR and load TCNT=0; if AUTO=0, EN clears the same edge (one-shot).
REQ-023 TCMP=0 SHALL disable counting (TCNT holds, no interrupt).
REQ-024 Any write to TCTL or TCMP SHALL reset TCNT to 0.
REQ-025 EN=0 SHALL freeze TCNT at its current value.
REQ-026 ISTAT write: bits written 1 clear; a set event and a clear on the same edge leaves the bit set.
REQ-027 INTR SHALL equal |(ISTAT & IMASK), registered-free combinational from flops; held until software clears.
REQ-028 LEDS SHALL drive the LED register directly.

Reset
REQ-029 RST_N=0 SHALL immediately clear LED, TCMP, TCTL, TCNT, ISTAT, IMASK, debounce counter, synchronizers; FSM to IDLE.
REQ-030 During and after reset until first event: LEDS=0, INTR=0, IOBUS_IN=0 except SW reads of synchronized SWITCHES (0 during reset).
REQ-031 Reset mid-debounce or mid-count SHALL discard progress; no ISTAT bit set on reset release.

Structure
REQ-032 Address constants, ISTAT/TCTL bit indices, and debounce state enum SHALL live in package otter_io_pkg.
REQ-033 Debounce synchronizer+FSM SHALL be sub-module btn_debounce (output: one-cycle press pulse).
REQ-034 Timer, register file and read mux stay in otter_io_ctrl.

Verification
REQ-035 Write 0x0000A5A5 to 0x11000020 -> LEDS=0xA5A5 next cycle; read returns 0x0000A5A5.
REQ-036 TCMP=5, IMASK=1, TCTL=3 -> ISTAT.TMR and INTR rise 5 cycles after TCTL write, repeating period 5; TCNT wraps 4->0.
REQ-037 TCMP=5, TCTL=1 -> single TMR event, TCTL reads 0 afterward, TCNT stays 0.
REQ-038 DEBOUNCE_CYCLES=8, BTN bounces 3 cycles then holds 20 -> exactly one ISTAT.BTN set; pulse of 5 cycles -> none.
REQ-039 ISTAT.TMR pending, write 0x1 to 0x1100004C on same edge as new timer match -> bit stays 1, INTR stays 1.
REQ-040 Assert RST_N=0 mid-count with ISTAT=3 -> all outputs 0 asynchronously; after release, no INTR without new event.
